// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: opcodes, FSM state encodings and the op legality rule for stack_seq.
package stack_seq_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOP   = 3'd0;
  localparam opcode_t OP_PUSHI = 3'd1;
  localparam opcode_t OP_DROP  = 3'd2;
  localparam opcode_t OP_DUP   = 3'd3;
  localparam opcode_t OP_OVER  = 3'd4;
  localparam opcode_t OP_SWAP  = 3'd5;
  localparam opcode_t OP_ADD   = 3'd6;
  localparam opcode_t OP_SUB   = 3'd7;

  // State k is the k-th cycle after the accepting edge.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_K1   = 2'd1;
  localparam logic [1:0] S_K2   = 2'd2;
  localparam logic [1:0] S_K3   = 2'd3;

  // Whether an op can run at the current entry count without over/underflow.
  function automatic logic op_legal(input opcode_t op, input int unsigned dep,
                                    input int unsigned cap, input logic arith_en);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_NOP:         ok = 1'b1;
      OP_PUSHI:       ok = (dep < cap);
      OP_DROP:        ok = (dep >= 1);
      OP_DUP:         ok = (dep >= 1) && (dep < cap);
      OP_OVER:        ok = (dep >= 2) && (dep < cap);
      OP_SWAP:        ok = (dep >= 2);
      OP_ADD, OP_SUB: ok = arith_en && (dep >= 2);
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// stack_seq_alu: combinational N+T / N-T for the ADD and SUB sequences (modulo 2^WIDTH).
module stack_seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] t,
  input  logic             sub,
  output logic [WIDTH-1:0] res_c
);

  assign res_c = sub ? (n - t) : (n + t);

endmodule

// File: rtl/stack_seq.sv
// stack_seq: accepts stack-machine ops and issues push/pop/load strobes to the operand stack.
// Build option STACK_SEQ_ARITH_EN enables ADD/SUB; without it opcodes 6/7 are rejected with err.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [2:0]                   op_code,
  input  logic [WIDTH-1:0]             op_imm,
  input  logic [WIDTH-1:0]             qtop,
  input  logic [WIDTH-1:0]             qnext,
  output logic                         push,
  output logic                         pop,
  output logic                         load,
  output logic [WIDTH-1:0]             d,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
`ifdef STACK_SEQ_ARITH_EN
  localparam logic ARITH_EN = 1'b1;
`else
  localparam logic ARITH_EN = 1'b0;
`endif

  logic [1:0]       state, state_nx;
  opcode_t          op_q, op_nx;
  logic [WIDTH-1:0] t_q, t_nx, n_q, n_nx;
  logic             push_nx, pop_nx, load_nx, done_nx, err_nx, ready_nx;
  logic [WIDTH-1:0] d_nx;
  logic [DW-1:0]    depth_nx;

`ifdef STACK_SEQ_ARITH_EN
  logic [WIDTH-1:0] alu_res_c;

  stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .n     (n_q),
    .t     (t_q),
    .sub   (op_q == OP_SUB),
    .res_c (alu_res_c)
  );
`endif

  // State, latched operands and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      t_q      <= '0;
      n_q      <= '0;
      push     <= 1'b0;
      pop      <= 1'b0;
      load     <= 1'b0;
      d        <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      depth    <= '0;
      op_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      op_q     <= op_nx;
      t_q      <= t_nx;
      n_q      <= n_nx;
      push     <= push_nx;
      pop      <= pop_nx;
      load     <= load_nx;
      d        <= d_nx;
      done     <= done_nx;
      err      <= err_nx;
      depth    <= depth_nx;
      op_ready <= ready_nx;
    end
  end

  // Next state and next strobe/data values; strobes are set one edge ahead of their cycle.
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    t_nx     = t_q;
    n_nx     = n_q;
    push_nx  = 1'b0;
    pop_nx   = 1'b0;
    load_nx  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    d_nx     = d;
    depth_nx = depth;

    if (push) begin
      depth_nx = depth + DW'(1);
    end else if (pop) begin
      depth_nx = depth - DW'(1);
    end

    case (state)
      S_IDLE: begin
        if (op_valid && op_ready) begin
          if (!op_legal(op_code, 32'(depth), DEPTH, ARITH_EN)) begin
            err_nx = 1'b1;
          end else begin
            op_nx    = op_code;
            t_nx     = qtop;
            n_nx     = qnext;
            state_nx = S_K1;
            case (op_code)
              OP_NOP:   done_nx = 1'b1;
              OP_PUSHI: begin push_nx = 1'b1; d_nx = op_imm; done_nx = 1'b1; end
              OP_DROP:  begin pop_nx  = 1'b1; done_nx = 1'b1; end
              OP_DUP:   begin push_nx = 1'b1; d_nx = qtop;   done_nx = 1'b1; end
              OP_OVER:  begin push_nx = 1'b1; d_nx = qnext;  done_nx = 1'b1; end
              default:  pop_nx = 1'b1;
            endcase
          end
        end
      end
      S_K1: begin
        state_nx = S_IDLE;
        if (op_q == OP_SWAP) begin
          load_nx  = 1'b1;
          d_nx     = t_q;
          state_nx = S_K2;
        end
`ifdef STACK_SEQ_ARITH_EN
        else if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
          load_nx  = 1'b1;
          d_nx     = alu_res_c;
          done_nx  = 1'b1;
          state_nx = S_K2;
        end
`endif
      end
      S_K2: begin
        state_nx = S_IDLE;
        if (op_q == OP_SWAP) begin
          push_nx  = 1'b1;
          d_nx     = n_q;
          done_nx  = 1'b1;
          state_nx = S_K3;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    ready_nx = (state_nx == S_IDLE);
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: stack_seq against a behavioural operand stack (DEPTH=4), table vectors plus random ops.
`timescale 1ns/1ps
module tb_stack_seq;

  localparam int unsigned W   = 16;
  localparam int unsigned CAP = 4;

  localparam logic [2:0] NOP = 3'd0, PUSHI = 3'd1, DROP = 3'd2, DUP = 3'd3;
  localparam logic [2:0] OVER = 3'd4, SWAP = 3'd5, ADD = 3'd6, SUB = 3'd7;
  localparam logic [1:0] SN = 2'd0, SPU = 2'd1, SPO = 2'd2, SLD = 2'd3;
`ifdef STACK_SEQ_ARITH_EN
  localparam logic ARITH = 1'b1;
`else
  localparam logic ARITH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         op_valid;
  logic         op_ready;
  logic [2:0]   op_code;
  logic [W-1:0] op_imm;
  logic [W-1:0] qtop, qnext;
  logic         push, pop, load, done, err;
  logic [W-1:0] d;
  logic [$clog2(CAP+1)-1:0] depth;

  int n_checks = 0;
  int n_pass   = 0;

  stack_seq #(.WIDTH(W), .DEPTH(CAP)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_imm(op_imm), .qtop(qtop), .qnext(qnext),
    .push(push), .pop(pop), .load(load), .d(d), .done(done), .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  // Operand stack the sequencer drives; mem[sp-1] is the top.
  logic [W-1:0] mem [CAP];
  int sp = 0;

  always @(posedge clk) begin
    if (!reset) sp <= 0;
    else if (push) begin
      if (sp < int'(CAP)) begin mem[sp] <= d; sp <= sp + 1; end
    end else if (pop) begin
      if (sp > 0) sp <= sp - 1;
    end else if (load) begin
      if (sp > 0) mem[sp-1] <= d;
    end
  end

  always_comb begin
    qtop  = '0;
    qnext = '0;
    if (sp > 0) qtop = mem[sp-1];
    if (sp > 1) qnext = mem[sp-2];
  end

  typedef struct {
    logic [2:0]   code;
    logic [W-1:0] imm;
    logic         err;
    int           done_k;
    logic [7:0]   seq;
    logic [W-1:0] top;
    logic [W-1:0] nxt;
    int           dep;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] sq(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    return {2'b00, c, b, a};
  endfunction

  function automatic void add_vec(input logic [2:0] code, input logic [W-1:0] imm, input logic e,
                                  input int dk, input logic [7:0] s, input logic [W-1:0] top,
                                  input logic [W-1:0] nxt, input int dep);
    vec_t v;
    v.code = code; v.imm = imm; v.err = e; v.done_k = dk; v.seq = s;
    v.top = top; v.nxt = nxt; v.dep = dep;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    op_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Issue one op and record strobes, done/err and op_ready for the four cycles after acceptance.
  task automatic do_op(input logic [2:0] code, input logic [W-1:0] imm,
                       output logic [7:0] seq, output int done_k, output logic got_err,
                       output logic [3:0] rdy, output int extra);
    int w;
    int ns;
    seq = '0; done_k = 0; got_err = 1'b0; rdy = '0; extra = 0; w = 0;
    while (op_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("ready_wait_timeout", 32'(w >= 20), 32'd0);
    op_code = code; op_imm = imm; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code = 3'($urandom);
    op_imm = W'($urandom);
    for (int k = 0; k < 4; k++) begin
      ns = int'(push) + int'(pop) + int'(load);
      if (ns > 1) extra++;
      if (push) seq[2*k +: 2] = SPU;
      else if (pop) seq[2*k +: 2] = SPO;
      else if (load) seq[2*k +: 2] = SLD;
      if (done) begin
        if (done_k == 0) done_k = k + 1;
        else extra++;
      end
      if (err) begin
        if (k == 0) got_err = 1'b1;
        else extra++;
      end
      rdy[k] = op_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_op(input string nm, input logic [2:0] code, input logic [W-1:0] imm,
                          input logic e_err, input int e_done, input logic [7:0] e_seq,
                          input logic [W-1:0] e_top, input logic [W-1:0] e_nxt, input int e_dep);
    logic [7:0] seq;
    int         dk;
    logic       ge;
    logic [3:0] rdy;
    logic [3:0] e_rdy;
    int         extra;
    do_op(code, imm, seq, dk, ge, rdy, extra);
    for (int k = 0; k < 4; k++) e_rdy[k] = (k + 1 > e_done);
    chk($sformatf("%s_err", nm), 32'(ge), 32'(e_err));
    chk($sformatf("%s_seq", nm), 32'(seq), 32'(e_seq));
    chk($sformatf("%s_done_k", nm), 32'(dk), 32'(e_done));
    chk($sformatf("%s_extra_pulses", nm), 32'(extra), 32'd0);
    chk($sformatf("%s_ready", nm), 32'(rdy), 32'(e_rdy));
    chk($sformatf("%s_depth", nm), 32'(depth), 32'(e_dep));
    chk($sformatf("%s_top", nm), 32'(qtop), 32'(e_top));
    chk($sformatf("%s_next", nm), 32'(qnext), 32'(e_nxt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  logic [W-1:0] rq[$];

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = '0; op_imm = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_ready", 32'(op_ready), 32'd0);
    chk("rst_strobes", 32'({push, pop, load, done, err}), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_depth", 32'(depth), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", 32'(op_ready), 32'd1);
    chk("rel_strobes", 32'({push, pop, load, done, err}), 32'd0);
    chk("rel_depth", 32'(depth), 32'd0);

    add_vec(NOP,   16'h0000, 1'b0, 1, sq(SN, SN, SN),    16'h0000, 16'h0000, 0);
    add_vec(DROP,  16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h0000, 16'h0000, 0);
    add_vec(PUSHI, 16'h1111, 1'b0, 1, sq(SPU, SN, SN),   16'h1111, 16'h0000, 1);
    add_vec(SWAP,  16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h1111, 16'h0000, 1);
    add_vec(OVER,  16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h1111, 16'h0000, 1);
    add_vec(PUSHI, 16'h2222, 1'b0, 1, sq(SPU, SN, SN),   16'h2222, 16'h1111, 2);
    add_vec(SWAP,  16'h0000, 1'b0, 3, sq(SPO, SLD, SPU), 16'h1111, 16'h2222, 2);
    add_vec(OVER,  16'h0000, 1'b0, 1, sq(SPU, SN, SN),   16'h2222, 16'h1111, 3);
    add_vec(DUP,   16'h0000, 1'b0, 1, sq(SPU, SN, SN),   16'h2222, 16'h2222, 4);
    add_vec(PUSHI, 16'h9999, 1'b1, 0, sq(SN, SN, SN),    16'h2222, 16'h2222, 4);
    add_vec(DUP,   16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h2222, 16'h2222, 4);
    add_vec(OVER,  16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h2222, 16'h2222, 4);
    add_vec(DROP,  16'h0000, 1'b0, 1, sq(SPO, SN, SN),   16'h2222, 16'h1111, 3);
    add_vec(DROP,  16'h0000, 1'b0, 1, sq(SPO, SN, SN),   16'h1111, 16'h2222, 2);
`ifdef STACK_SEQ_ARITH_EN
    add_vec(ADD,   16'h0000, 1'b0, 2, sq(SPO, SLD, SN),  16'h3333, 16'h0000, 1);
`else
    add_vec(ADD,   16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h1111, 16'h2222, 2);
    add_vec(SUB,   16'h0000, 1'b1, 0, sq(SN, SN, SN),    16'h1111, 16'h2222, 2);
`endif
    foreach (tbl[i])
      check_op($sformatf("row%0d", i), tbl[i].code, tbl[i].imm, tbl[i].err, tbl[i].done_k,
               tbl[i].seq, tbl[i].top, tbl[i].nxt, tbl[i].dep);

`ifdef STACK_SEQ_ARITH_EN
    do_reset();
    check_op("sub_a_p1", PUSHI, 16'h0003, 1'b0, 1, sq(SPU, SN, SN), 16'h0003, 16'h0000, 1);
    check_op("sub_a_p2", PUSHI, 16'h0001, 1'b0, 1, sq(SPU, SN, SN), 16'h0001, 16'h0003, 2);
    check_op("sub_a", SUB, 16'h0000, 1'b0, 2, sq(SPO, SLD, SN), 16'h0002, 16'h0000, 1);
    do_reset();
    check_op("sub_b_p1", PUSHI, 16'h0000, 1'b0, 1, sq(SPU, SN, SN), 16'h0000, 16'h0000, 1);
    check_op("sub_b_p2", PUSHI, 16'h0001, 1'b0, 1, sq(SPU, SN, SN), 16'h0001, 16'h0000, 2);
    check_op("sub_b", SUB, 16'h0000, 1'b0, 2, sq(SPO, SLD, SN), 16'hFFFF, 16'h0000, 1);
`endif

    // Reset asserted in the load cycle of a SWAP.
    do_reset();
    check_op("mid_p1", PUSHI, 16'hAAAA, 1'b0, 1, sq(SPU, SN, SN), 16'hAAAA, 16'h0000, 1);
    check_op("mid_p2", PUSHI, 16'h5555, 1'b0, 1, sq(SPU, SN, SN), 16'h5555, 16'hAAAA, 2);
    op_code = SWAP; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    chk("mid_k1_pop", 32'(pop), 32'd1);
    @(posedge clk);
    #1;
    chk("mid_k2_load", 32'({push, pop, load}), 32'b001);
    chk("mid_k2_d", 32'(d), 32'h5555);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({push, pop, load, done, err}), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_ready", 32'(op_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_after%0d_strobes", k), 32'({push, pop, load, done, err}), 32'd0);
      chk($sformatf("mid_after%0d_ready", k), 32'(op_ready), 32'd1);
    end

    // Random ops against a queue-based stack model; rq[0] is the top.
    do_reset();
    rq.delete();
    for (int i = 0; i < 250; i++) begin
      logic [2:0]   c;
      logic [W-1:0] im;
      logic [W-1:0] tmp;
      logic         legal;
      int           dk;
      logic [7:0]   es;
      int           n;
      c = 3'($urandom_range(0, 7));
      im = W'($urandom);
      n = rq.size();
      case (c)
        NOP:     legal = 1'b1;
        PUSHI:   legal = (n < int'(CAP));
        DROP:    legal = (n >= 1);
        DUP:     legal = (n >= 1) && (n < int'(CAP));
        OVER:    legal = (n >= 2) && (n < int'(CAP));
        SWAP:    legal = (n >= 2);
        default: legal = ARITH && (n >= 2);
      endcase
      dk = 0;
      es = sq(SN, SN, SN);
      if (legal) begin
        case (c)
          NOP:   dk = 1;
          PUSHI: begin rq.push_front(im); dk = 1; es = sq(SPU, SN, SN); end
          DROP:  begin void'(rq.pop_front()); dk = 1; es = sq(SPO, SN, SN); end
          DUP:   begin rq.push_front(rq[0]); dk = 1; es = sq(SPU, SN, SN); end
          OVER:  begin rq.push_front(rq[1]); dk = 1; es = sq(SPU, SN, SN); end
          SWAP:  begin
            tmp = rq[0]; rq[0] = rq[1]; rq[1] = tmp;
            dk = 3; es = sq(SPO, SLD, SPU);
          end
          ADD:   begin tmp = rq.pop_front(); rq[0] = rq[0] + tmp; dk = 2; es = sq(SPO, SLD, SN); end
          default: begin tmp = rq.pop_front(); rq[0] = rq[0] - tmp; dk = 2; es = sq(SPO, SLD, SN); end
        endcase
      end
      check_op($sformatf("rnd%0d_op%0d", i, c), c, im, !legal, dk, es,
               (rq.size() > 0) ? rq[0] : W'(0), (rq.size() > 1) ? rq[1] : W'(0), rq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
